serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor. Computes diff = a - b - bin on WIDTH-bit operands.
- Processes BITS_PER_CYCLE bits per clock, LSB first, through a chain of 1-bit full-subtractor cells. The borrow is carried between cycles in a register.
- Successor to the single-bit combinational full subtractor: adds width generality, a start/done handshake and signed-overflow detection.
- Intended for area-constrained datapaths where latency can be traded for cells.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 2.
- BITS_PER_CYCLE, 1, bits processed per cycle. Must divide WIDTH exactly; elaboration fails otherwise.

Ports:
- clk  input  1  clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in to bit 0
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result is valid
- diff  output  WIDTH  result, a - b - bin mod 2^WIDTH
- bout  output  1  borrow out of the MSB; 1 iff unsigned a < b + bin
- ovf  output  1  signed two's-complement overflow: borrow into MSB XOR borrow out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy, done, diff, bout and ovf all go to 0.
  - Internal operand registers, step counter and borrow register are cleared.
- Let STEPS = WIDTH / BITS_PER_CYCLE.
- States:
  - IDLE: waits for start.
  - RUN: performs the subtraction, BITS_PER_CYCLE bits per cycle.
  - DONE: lasts exactly one cycle.
- IDLE:
  - start=1 at a rising edge latches a, b and bin into the operand shift registers and borrow register.
  - Clears the step counter and moves to RUN. busy goes high on the same edge.
- RUN:
  - Each cycle, the low BITS_PER_CYCLE bits of the operand registers feed the cell chain, with the registered borrow as cell-0 borrow-in.
  - The result bits shift into the result register from the top. Operands shift right by BITS_PER_CYCLE.
  - The chain borrow-out is registered. The counter increments.
  - On the edge completing step STEPS-1:
    - diff gets the full result; bout gets the final borrow.
    - ovf gets the borrow into the MSB cell XOR the borrow out of it.
    - Move to DONE: done=1, busy=0.
- Latency: start sampled at edge 0 means done is high in the cycle after edge STEPS. Example: WIDTH=8, BITS_PER_CYCLE=1 gives done 8 cycles after start.
- DONE:
  - done is high for exactly one cycle, then the block returns to IDLE.
  - start=1 during DONE is accepted exactly as in IDLE: new operands latched, straight to RUN, no idle gap. Back-to-back throughput is therefore one result every STEPS+1 cycles.
- start while busy=1 is ignored. Operand inputs are don't-care while busy.
- diff, bout and ovf hold their last result until the next completion. They are not updated during RUN; partial results are never visible.
- rst_n asserted mid-RUN aborts the operation:
  - No done pulse is generated.
  - Outputs go to 0.
  - After release, the block is in IDLE and the next start behaves normally.
- Arithmetic: unsigned modular subtraction; no saturation. ovf is meaningful only for signed interpretation. bout is meaningful only for unsigned interpretation.

Decomposition:
- Shared package:
  - State encoding enum (IDLE, RUN, DONE).
  - Localparam STEPS.
  - Step-counter width $clog2(STEPS+1).
- Sub-module fs_cell:
  - Single-bit full-subtractor cell with inputs x, y, bi and outputs d, bo.
  - d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
  - serial_subtractor instantiates BITS_PER_CYCLE copies in a borrow chain.

Test Plan:
- WIDTH=8, BPC=1: a=0x05, b=0x03, bin=0 → done exactly 8 cycles after start; diff=0x02, bout=0, ovf=0; busy high for 8 cycles.
- WIDTH=8, BPC=1:
  - a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, ovf=0.
  - a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1.
  - a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, ovf=0.
- WIDTH=8, BPC=4: a=0x7F, b=0xFF, bin=0 → done 2 cycles after start; diff=0x80, bout=1, ovf=1.
- Handshake:
  - Pulse start again at cycles 3 and 5 of an operation with different operands → ignored; the first result is unchanged.
  - start asserted during the done cycle → second op accepted; second done pulse exactly STEPS+1 cycles after the first.
- Reset mid-op: drop rst_n at cycle 4 of 8 → busy, done, diff, bout, ovf = 0 immediately. After release, a new start with 0x10-0x01 gives 0x0F after 8 cycles; no stray done pulse.
- WIDTH=4, BPC ∈ {1, 2, 4}: exhaustive sweep of all 512 (a, b, bin) combinations against the behavioural model a - b - bin. Checks diff, bout and ovf, and latency = STEPS for every case.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and sizing helpers for the serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int steps_f(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int cnt_w_f(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// fs_cell: single-bit full subtractor, d = x - y - bi with borrow out bo
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, BITS_PER_CYCLE bits per clock, LSB first
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int STEPS = steps_f(WIDTH, BITS_PER_CYCLE);
    localparam int CW    = cnt_w_f(STEPS);

    if (WIDTH < 2 || WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    state_t                    state, nstate;
    logic [WIDTH-1:0]          ra, rb, acc, acc_n;
    logic                      br, last, load;
    logic [CW-1:0]             cnt;
    logic [BITS_PER_CYCLE-1:0] d;
    logic [BITS_PER_CYCLE:0]   c;

    assign c[0] = br;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
        fs_cell u_cell (.x(ra[i]), .y(rb[i]), .bi(c[i]), .d(d[i]), .bo(c[i+1]));
    end

    assign busy = state == RUN;
    assign done = state == DONE;

    always_comb begin
        last   = cnt == CW'(STEPS - 1);
        load   = start && state != RUN;
        acc_n  = (acc >> BITS_PER_CYCLE) | (WIDTH'(d) << (WIDTH - BITS_PER_CYCLE));
        nstate = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    // Result bits enter at the top so the LSB slice lands at bit 0 after STEPS shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= nstate;
            if (load) begin
                ra  <= a;
                rb  <= b;
                br  <= bin;
                cnt <= '0;
            end else if (state == RUN) begin
                ra  <= ra >> BITS_PER_CYCLE;
                rb  <= rb >> BITS_PER_CYCLE;
                br  <= c[BITS_PER_CYCLE];
                acc <= acc_n;
                cnt <= cnt + CW'(1);
                if (last) begin
                    diff <= acc_n;
                    bout <= c[BITS_PER_CYCLE];
                    ovf  <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
                end
            end
        end
    end
endmodule
